// File: rtl/rc_tdc_pkg.sv
// rtl/rc_tdc_pkg.sv - shared state codes and default constants for the RC measurement path
package rc_tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CHARGE  = 3'd2,
    ST_CALC    = 3'd3,
    ST_CONVERT = 3'd4,
    ST_PUBLISH = 3'd5,
    ST_SETTLE  = 3'd6
  } state_t;

  localparam int          CNT_W_DEF     = 24;
  localparam int          DIS_SHIFT_DEF = 2;
  localparam int          MIN_DIS_DEF   = 1024;
  localparam logic [23:0] TIMEOUT_DEF   = 24'hFFFFF0;

endpackage

// File: rtl/rc_sync2.sv
// rtl/rc_sync2.sv - two-flop synchronizer for a single asynchronous input
module rc_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rc_measure_sequencer.sv
// rtl/rc_measure_sequencer.sv - charge/capture/compute/publish/discharge sequencer for RC time measurement
module rc_measure_sequencer
  import rc_tdc_pkg::*;
#(
  parameter int               CNT_W     = CNT_W_DEF,
  parameter int               DIS_SHIFT = DIS_SHIFT_DEF,
  parameter int               MIN_DIS   = MIN_DIS_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             step_input,
  output logic             step_set,
  output logic             timer_clear,
  input  logic [CNT_W-1:0] timer_count,
  input  logic             timer_overflow,
  output logic             calc_start,
  output logic [CNT_W-1:0] calc_time,
  input  logic             calc_done,
  output logic             bcd_start,
  input  logic             bcd_dv,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_err,
  output logic             busy,
  output logic [2:0]       state_o
);

  localparam int DW = CNT_W + DIS_SHIFT;

  state_t        state, state_next;
  logic          step_sync;
  logic [DW-1:0] dis_cnt;
  logic          start_pending;
  logic          capture, timeout_hit, calc_ok, settle_done, leave_to_clear;

  // Discharge wait scales with the measured charge time but never drops below MIN_DIS.
  function automatic logic [DW-1:0] dis_wait(input logic [CNT_W-1:0] t);
    logic [DW-1:0] w;
    w = DW'(t) << DIS_SHIFT;
    return (w > DW'(MIN_DIS)) ? w : DW'(MIN_DIS);
  endfunction

  rc_sync2 u_step_sync (
    .clk   (clk),
    .reset (reset),
    .d     (step_input),
    .q     (step_sync)
  );

  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    timeout_hit    = 1'b0;
    calc_ok        = 1'b0;
    settle_done    = 1'b0;
    leave_to_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || start_pending) begin
          state_next     = ST_CLEAR;
          leave_to_clear = 1'b1;
        end
      end
      ST_CLEAR: state_next = ST_CHARGE;
      ST_CHARGE: begin
        if (step_sync) begin
          capture    = 1'b1;
          state_next = ST_CALC;
        end else if (timer_overflow || (timer_count >= TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_next  = ST_PUBLISH;
        end
      end
      ST_CALC: begin
        if (calc_done) begin
          calc_ok    = 1'b1;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: if (bcd_dv) state_next = ST_PUBLISH;
      ST_PUBLISH: if (res_ready) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (dis_cnt == '0) begin
          settle_done = 1'b1;
          if (continuous || start_pending) begin
            state_next     = ST_CLEAR;
            leave_to_clear = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      calc_time     <= '0;
      calc_start    <= 1'b0;
      bcd_start     <= 1'b0;
      res_err       <= 1'b0;
      dis_cnt       <= '0;
      start_pending <= 1'b0;
    end else begin
      state      <= state_next;
      calc_start <= capture;
      bcd_start  <= calc_ok;
      if (capture || timeout_hit) calc_time <= timer_count;
      // Counter runs regardless of state so settling overlaps computation and publishing.
      if (capture)                dis_cnt <= dis_wait(timer_count);
      else if (timeout_hit)       dis_cnt <= dis_wait(TIMEOUT);
      else if (dis_cnt != '0)     dis_cnt <= dis_cnt - 1'b1;
      if (timeout_hit)            res_err <= 1'b1;
      else if (settle_done)       res_err <= 1'b0;
      if (leave_to_clear)         start_pending <= 1'b0;
      else if (start && busy)     start_pending <= 1'b1;
    end
  end

  assign step_set    = (state == ST_CHARGE);
  assign timer_clear = (state == ST_CLEAR);
  assign res_valid   = (state == ST_PUBLISH);
  assign busy        = (state != ST_IDLE);
  assign state_o     = state;

endmodule

// File: tb/tb_rc_measure_sequencer.sv
// tb/tb_rc_measure_sequencer.sv - directed bench with charge-timer model and auto-responding calculator/BCD stubs
module tb_rc_measure_sequencer;

  localparam int CW = 24;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0;
  logic          step_input = 1'b0, calc_done = 1'b0, bcd_dv = 1'b0, res_ready = 1'b0;
  logic [CW-1:0] timer_count, calc_time;
  logic          timer_overflow, step_set, timer_clear, calc_start, bcd_start;
  logic          res_valid, res_err, busy;
  logic [2:0]    state_o;

  logic          start_t = 1'b0, res_ready_t = 1'b0;
  logic [CW-1:0] timer_count_t, calc_time_t;
  logic          timer_overflow_t, step_set_t, timer_clear_t, calc_start_t, bcd_start_t;
  logic          res_valid_t, res_err_t, busy_t;
  logic [2:0]    state_o_t;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int step_at = 1000;
  logic auto_resp = 1'b0, man_done = 1'b0, man_dv = 1'b0;
  int n_cs = 0, n_bs = 0, n_clr = 0, n_cs_t = 0, n_bs_t = 0, n_viol = 0;
  logic p_cs = 1'b0, p_bs = 1'b0, p_tc = 1'b0;
  logic [CW-1:0] results[$];

  rc_measure_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .step_input(step_input), .step_set(step_set), .timer_clear(timer_clear),
    .timer_count(timer_count), .timer_overflow(timer_overflow),
    .calc_start(calc_start), .calc_time(calc_time), .calc_done(calc_done),
    .bcd_start(bcd_start), .bcd_dv(bcd_dv), .res_valid(res_valid),
    .res_ready(res_ready), .res_err(res_err), .busy(busy), .state_o(state_o)
  );

  rc_measure_sequencer #(.TIMEOUT(24'd500)) dut_to (
    .clk(clk), .reset(reset), .start(start_t), .continuous(1'b0),
    .step_input(1'b0), .step_set(step_set_t), .timer_clear(timer_clear_t),
    .timer_count(timer_count_t), .timer_overflow(timer_overflow_t),
    .calc_start(calc_start_t), .calc_time(calc_time_t), .calc_done(1'b0),
    .bcd_start(bcd_start_t), .bcd_dv(1'b0), .res_valid(res_valid_t),
    .res_ready(res_ready_t), .res_err(res_err_t), .busy(busy_t), .state_o(state_o_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Charge timers: clear on pulse, count while excited, saturate at all-ones.
  always @(posedge clk) begin
    if (reset || timer_clear) timer_count <= '0;
    else if (step_set && timer_count != '1) timer_count <= timer_count + 1'b1;
    if (reset || timer_clear_t) timer_count_t <= '0;
    else if (step_set_t && timer_count_t != '1) timer_count_t <= timer_count_t + 1'b1;
  end
  assign timer_overflow   = (timer_count == '1);
  assign timer_overflow_t = (timer_count_t == '1);

  // Comparator trips two counts early so the synchronized edge lines up with timer_count == step_at.
  always @(negedge clk) begin
    #1;
    step_input = step_set && (int'(timer_count) >= step_at - 2);
    calc_done  = (auto_resp && calc_start) || man_done;
    bcd_dv     = (auto_resp && bcd_start) || man_dv;
  end

  always @(negedge clk) begin
    #2;
    if (calc_start) n_cs++;
    if (bcd_start) n_bs++;
    if (timer_clear) n_clr++;
    if (calc_start_t) n_cs_t++;
    if (bcd_start_t) n_bs_t++;
    if (res_valid && res_ready) results.push_back(calc_time);
    if ((step_set && state_o != 3'd2) || (step_set_t && state_o_t != 3'd2)) n_viol++;
    if ((calc_start && p_cs) || (bcd_start && p_bs) || (timer_clear && p_tc)) n_viol++;
    p_cs = calc_start;
    p_bs = bcd_start;
    p_tc = timer_clear;
  end

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({step_set, timer_clear, calc_start, bcd_start, res_valid, res_err, busy} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0000000", {step_set, timer_clear, calc_start, bcd_start, res_valid, res_err, busy}); else n_pass++;
    n_chk++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
    n_chk++; if (calc_time !== '0) $display("FAIL reset_calc_time: got %0d want 0", calc_time); else n_pass++;
    n_chk++; if (busy_t !== 1'b0) $display("FAIL reset_busy_t: got %b want 0", busy_t); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_measure(input int at, input int settle, input string nm);
    int n, t0, cs0, bs0;
    cs0 = n_cs; bs0 = n_bs;
    auto_resp = 1'b1; res_ready = 1'b1; step_at = at;
    pulse_start;
    n = 0; while (!calc_start && n < 3000) begin @(negedge clk); n++; end
    n_chk++; if (calc_start !== 1'b1) $display("FAIL %s_calc_start_wait: got %b want 1", nm, calc_start); else n_pass++;
    t0 = cyc;
    n_chk++; if (calc_time !== CW'(at)) $display("FAIL %s_calc_time: got %0d want %0d", nm, calc_time, at); else n_pass++;
    n_chk++; if (step_set !== 1'b0) $display("FAIL %s_step_set_off: got %b want 0", nm, step_set); else n_pass++;
    n = 0; while (!res_valid && n < 20) begin @(negedge clk); n++; end
    n_chk++; if (res_valid !== 1'b1) $display("FAIL %s_res_valid: got %b want 1", nm, res_valid); else n_pass++;
    n_chk++; if (res_err !== 1'b0) $display("FAIL %s_res_err: got %b want 0", nm, res_err); else n_pass++;
    n = 0; while (busy && n < 6000) begin @(negedge clk); n++; end
    n_chk++; if (cyc - t0 !== settle) $display("FAIL %s_settle_cycles: got %0d want %0d", nm, cyc - t0, settle); else n_pass++;
    n_chk++; if (state_o !== 3'd0) $display("FAIL %s_end_state: got %0d want 0", nm, state_o); else n_pass++;
    @(negedge clk);
    n_chk++; if (n_cs - cs0 !== 1) $display("FAIL %s_calc_start_count: got %0d want 1", nm, n_cs - cs0); else n_pass++;
    n_chk++; if (n_bs - bs0 !== 1) $display("FAIL %s_bcd_start_count: got %0d want 1", nm, n_bs - bs0); else n_pass++;
  endtask

  task automatic test_timeout;
    int n, t0;
    res_ready_t = 1'b1;
    @(negedge clk) start_t = 1'b1;
    @(negedge clk) start_t = 1'b0;
    n = 0; while (!res_valid_t && n < 1000) begin @(negedge clk); n++; end
    n_chk++; if (res_valid_t !== 1'b1) $display("FAIL to_res_valid: got %b want 1", res_valid_t); else n_pass++;
    n_chk++; if (res_err_t !== 1'b1) $display("FAIL to_res_err: got %b want 1", res_err_t); else n_pass++;
    n_chk++; if (calc_time_t !== 24'd500) $display("FAIL to_calc_time: got %0d want 500", calc_time_t); else n_pass++;
    n_chk++; if (step_set_t !== 1'b0) $display("FAIL to_step_set: got %b want 0", step_set_t); else n_pass++;
    t0 = cyc;
    n = 0; while (busy_t && n < 3000) begin @(negedge clk); n++; end
    n_chk++; if (cyc - t0 !== 2001) $display("FAIL to_settle_cycles: got %0d want 2001", cyc - t0); else n_pass++;
    n_chk++; if (res_err_t !== 1'b0) $display("FAIL to_res_err_clear: got %b want 0", res_err_t); else n_pass++;
    @(negedge clk);
    n_chk++; if (n_cs_t + n_bs_t !== 0) $display("FAIL to_no_calc_bcd: got %0d want 0", n_cs_t + n_bs_t); else n_pass++;
  endtask

  task automatic test_backpressure;
    int n;
    auto_resp = 1'b1; res_ready = 1'b0; step_at = 1000;
    pulse_start;
    n = 0; while (!res_valid && n < 2000) begin @(negedge clk); n++; end
    repeat (5000) @(negedge clk);
    n_chk++; if (res_valid !== 1'b1) $display("FAIL bp_res_valid_held: got %b want 1", res_valid); else n_pass++;
    n_chk++; if (state_o !== 3'd5) $display("FAIL bp_state_publish: got %0d want 5", state_o); else n_pass++;
    res_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (state_o !== 3'd6) $display("FAIL bp_state_settle: got %0d want 6", state_o); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL bp_res_valid_drop: got %b want 0", res_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL bp_settle_immediate: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_continuous;
    int n, cs0, clr0;
    logic [CW-1:0] exp_res [4];
    exp_res[0] = 24'd200; exp_res[1] = 24'd300; exp_res[2] = 24'd400; exp_res[3] = 24'd150;
    results.delete();
    @(negedge clk);
    cs0 = n_cs; clr0 = n_clr;
    auto_resp = 1'b1; res_ready = 1'b1; continuous = 1'b1; step_at = 200;
    pulse_start;
    n = 0; while (!calc_start && n < 1000) begin @(negedge clk); n++; end
    step_at = 300;
    @(negedge clk);
    n = 0; while (!calc_start && n < 3000) begin @(negedge clk); n++; end
    step_at = 400;
    @(negedge clk);
    n = 0; while (state_o != 3'd2 && n < 3000) begin @(negedge clk); n++; end
    n_chk++; if (state_o !== 3'd2) $display("FAIL cont_third_charge: got %0d want 2", state_o); else n_pass++;
    repeat (50) @(negedge clk);
    pulse_start;
    pulse_start;
    n = 0; while (!calc_start && n < 1000) begin @(negedge clk); n++; end
    continuous = 1'b0; step_at = 150;
    @(negedge clk);
    n = 0; while (!calc_start && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0; while (busy && n < 3000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    n_chk++; if (state_o !== 3'd0) $display("FAIL cont_final_idle: got %0d want 0", state_o); else n_pass++;
    n_chk++; if (n_cs - cs0 !== 4) $display("FAIL cont_measure_count: got %0d want 4", n_cs - cs0); else n_pass++;
    n_chk++; if (n_clr - clr0 !== 4) $display("FAIL cont_clear_count: got %0d want 4", n_clr - clr0); else n_pass++;
    n_chk++; if (results.size() !== 4) $display("FAIL cont_result_count: got %0d want 4", results.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= results.size()) $display("FAIL cont_result_%0d: got none want %0d", i, exp_res[i]);
      else if (results[i] !== exp_res[i]) $display("FAIL cont_result_%0d: got %0d want %0d", i, results[i], exp_res[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int n, bs0;
    auto_resp = 1'b0; res_ready = 1'b1; step_at = 1000;
    pulse_start;
    n = 0; while (state_o != 3'd2 && n < 10) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (state_o !== 3'd0) $display("FAIL rst_charge_state: got %0d want 0", state_o); else n_pass++;
    n_chk++; if ({step_set, timer_clear, calc_start, bcd_start, res_valid, res_err, busy, calc_time} !== '0)
      $display("FAIL rst_charge_outputs: got step_set %b busy %b calc_time %0d want all 0", step_set, busy, calc_time); else n_pass++;
    reset = 1'b0;
    bs0 = n_bs;
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
    man_dv = 1'b1;   @(negedge clk); man_dv = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (state_o !== 3'd0 || n_bs != bs0) $display("FAIL rst_charge_ignore: got state %0d bcd_starts %0d want 0 0", state_o, n_bs - bs0); else n_pass++;

    step_at = 50;
    pulse_start;
    n = 0; while (!calc_start && n < 200) begin @(negedge clk); n++; end
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
    n_chk++; if (state_o !== 3'd4) $display("FAIL rst_reach_convert: got %0d want 4", state_o); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (state_o !== 3'd0) $display("FAIL rst_convert_state: got %0d want 0", state_o); else n_pass++;
    n_chk++; if ({step_set, timer_clear, calc_start, bcd_start, res_valid, res_err, busy, calc_time} !== '0)
      $display("FAIL rst_convert_outputs: got res_valid %b busy %b calc_time %0d want all 0", res_valid, busy, calc_time); else n_pass++;
    reset = 1'b0;
    man_dv = 1'b1; @(negedge clk); man_dv = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (state_o !== 3'd0 || res_valid !== 1'b0) $display("FAIL rst_convert_ignore: got state %0d res_valid %b want 0 0", state_o, res_valid); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_measure(1000, 4001, "single");
    test_measure(10, 1025, "short");
    test_timeout;
    test_backpressure;
    test_continuous;
    test_reset_mid;
    n_chk++; if (n_viol !== 0) $display("FAIL pulse_and_step_set_rules: got %0d violations want 0", n_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
